contador_n: RTL and testbench
=============================

CONTADOR_N -- requirements
Module: contador_n

Interface
REQ-001 Parameter WIDTH, default 4: bit width of D, LIMIT and Q; legal range 2..32.
REQ-002 Parameter STEP, default 3: decrement size in mode 10; legal range 1..2^WIDTH-1.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port RESET  input  1  synchronous, active-high reset.
REQ-005 Port ENABLE  input  1  count/load enable; 0 = hold.
REQ-006 Port MODO  input  2  operating mode: 00 up by 1, 01 down by 1, 10 down by STEP, 11 parallel load.
REQ-007 Port D  input  WIDTH  parallel-load value.
REQ-008 Port LIMIT  input  WIDTH  modulus top; count range is 0..LIMIT, sampled every cycle.
REQ-009 Port Q  output  WIDTH  registered count value.
REQ-010 Port RCO  output  1  registered ripple-carry/borrow pulse.
REQ-011 Port LOAD  output  1  registered load-acknowledge pulse.
REQ-012 One clock; reset is synchronous and active-high, ports named clk and RESET.

Function
REQ-013 Q, RCO and LOAD shall be flops updated on rising clk; each is a pure function of the previous Q and the inputs sampled at that edge.
REQ-014 ENABLE=0 (RESET=0): Q shall hold; RCO=0, LOAD=0 next cycle.
REQ-015 MODO=00: Q>=LIMIT -> Q=0, RCO=1; else Q=Q+1, RCO=0.
REQ-016 MODO=01: Q==0 -> Q=LIMIT, RCO=1; else Q=Q-1, RCO=0.
REQ-017 MODO=10: Q>=STEP -> Q=Q-STEP, RCO=0; else Q=LIMIT+1+Q-STEP, RCO=1, computed in WIDTH+1 bits; if that result is negative (STEP>LIMIT+1+Q), Q=LIMIT.
REQ-018 MODO=11: Q=D unconditionally (D>LIMIT allowed), LOAD=1, RCO=0.
REQ-019 LOAD shall be 0 in all modes other than 11.
REQ-020 Q>LIMIT (LIMIT lowered or D>LIMIT): mode 00 wraps to 0 with RCO=1; modes 01/10 decrement normally with no RCO until borrow.
REQ-021 RCO and LOAD shall be single-cycle pulses, high only in the cycle following the qualifying edge, never simultaneously high.
REQ-022 No intermediate arithmetic shall truncate before range checks; no X shall propagate from legal inputs.

Reset
REQ-023 RESET=1 at a rising edge shall set Q=0, RCO=0, LOAD=0, overriding ENABLE and MODO.
REQ-024 RESET asserted mid-count shall take effect at the next edge; first post-reset count starts from Q=0.
REQ-025 Without RESET after power-up, outputs are undefined; benches shall reset at least one cycle.

Configuration
REQ-026 Macro CONTADOR_N_SAT_EN defined: wrap replaced by saturation -- mode 00 holds Q=LIMIT, modes 01/10 hold Q=0 (mode 10 with Q<STEP goes to 0); RCO=1 every enabled cycle in which Q is at/clamped to the bound.
REQ-027 Macro undefined: modular wrap per REQ-015..REQ-017; RCO is a pulse.
REQ-028 Macro shall not change ports, reset values, load or hold behaviour.

Verification (WIDTH=4, STEP=3, LIMIT=9 unless stated)
REQ-029 RESET=1 two cycles with ENABLE=1, MODO=00 -> Q=0, RCO=0, LOAD=0 each cycle.
REQ-030 MODO=00 from Q=0 for 11 cycles -> Q 1..9, then 0 with RCO=1 exactly once, then 1.
REQ-031 MODO=11, D=4, then MODO=10 three cycles -> Q=4 LOAD=1; Q=1; Q=8 RCO=1; Q=5.
REQ-032 Q=5, ENABLE=0 three cycles, MODO=01 -> Q holds 5, RCO=LOAD=0; ENABLE=1 -> Q=4.
REQ-033 Load D=15, MODO=00 -> Q=15 then Q=0 with RCO=1; RESET asserted at Q=7 mid-count -> Q=0 next edge.
REQ-034 CONTADOR_N_SAT_EN defined, MODO=00 from Q=8 -> Q=9, 9, 9 with RCO=1 while held; MODO=10 from Q=2 -> Q=0, RCO=1.

Source files
------------

// File: rtl/contador_n.sv
// Mode-selectable modulo counter with parallel load, ripple-carry/borrow and load-acknowledge pulses.
// Define CONTADOR_N_SAT_EN to replace the modular wrap with saturation at the count bounds.
module contador_n #(
  parameter int WIDTH = 4,
  parameter int STEP  = 3
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             LOAD
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [WIDTH-1:0] STEPW = WIDTH'(STEP);

  logic [WIDTH-1:0] nextq;
  logic             nextrco;
  logic             nextload;

`ifndef CONTADOR_N_SAT_EN
  // LIMIT+1+Q needs one extra bit; a value below STEP means the borrow overshoots the range.
  localparam logic [WIDTH:0] STEPX = (WIDTH+1)'(STEP);
  logic [WIDTH:0] sum;
  assign sum = {1'b0, LIMIT} + {1'b0, Q} + (WIDTH+1)'(1);
`endif

  always_comb begin
    nextq    = Q;
    nextrco  = 1'b0;
    nextload = 1'b0;
    case (MODO)
      MODE_UP: begin
        if (Q >= LIMIT) begin
          nextrco = 1'b1;
`ifdef CONTADOR_N_SAT_EN
          nextq   = LIMIT;
`else
          nextq   = '0;
`endif
        end else begin
          nextq = Q + WIDTH'(1);
        end
      end
      MODE_DOWN: begin
        if (Q == '0) begin
          nextrco = 1'b1;
`ifdef CONTADOR_N_SAT_EN
          nextq   = '0;
`else
          nextq   = LIMIT;
`endif
        end else begin
          nextq = Q - WIDTH'(1);
        end
      end
      MODE_STEP: begin
        if (Q >= STEPW) begin
          nextq = Q - STEPW;
        end else begin
          nextrco = 1'b1;
`ifdef CONTADOR_N_SAT_EN
          nextq   = '0;
`else
          nextq   = (sum < STEPX) ? LIMIT : WIDTH'(sum - STEPX);
`endif
        end
      end
      MODE_LOAD: begin
        nextq    = D;
        nextload = 1'b1;
      end
      default: begin
        nextq = Q;
      end
    endcase
  end

  // Disabled cycles hold the count but still clear both pulses.
  always_ff @(posedge clk) begin
    if (RESET) begin
      Q    <= '0;
      RCO  <= 1'b0;
      LOAD <= 1'b0;
    end else if (ENABLE) begin
      Q    <= nextq;
      RCO  <= nextrco;
      LOAD <= nextload;
    end else begin
      RCO  <= 1'b0;
      LOAD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_n.sv
// Directed self-checking bench for contador_n (WIDTH=4, STEP=3, LIMIT=9 by default).
// Saturation checks run only when CONTADOR_N_SAT_EN is defined for the build.
module tb_contador_n;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] modo;
  logic [3:0] d;
  logic [3:0] limit;
  logic [3:0] q;
  logic       rco;
  logic       load;

  int checks;
  int fails;

  contador_n #(.WIDTH(4), .STEP(3)) dut (
    .clk    (clk),
    .RESET  (reset),
    .ENABLE (enable),
    .MODO   (modo),
    .D      (d),
    .LIMIT  (limit),
    .Q      (q),
    .RCO    (rco),
    .LOAD   (load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; modo = 2'b00; d = 4'd0; limit = 4'd9;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 3;
      if (q !== 4'd0) begin fails++; $display("[TB] FAIL reset_q cycle %0d: got %0d want 0", i, q); end
      if (rco !== 1'b0) begin fails++; $display("[TB] FAIL reset_rco cycle %0d: got %b want 0", i, rco); end
      if (load !== 1'b0) begin fails++; $display("[TB] FAIL reset_load cycle %0d: got %b want 0", i, load); end
    end
  endtask

  task automatic test_count_up();
    logic [3:0] expq [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
    logic       expr [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    reset = 1'b0; modo = 2'b00;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks += 2;
      if (q !== expq[i]) begin fails++; $display("[TB] FAIL up_q step %0d: got %0d want %0d", i, q, expq[i]); end
      if (rco !== expr[i]) begin fails++; $display("[TB] FAIL up_rco step %0d: got %b want %b", i, rco, expr[i]); end
    end
  endtask

  task automatic test_step_down();
    logic [1:0] modes [4] = '{2'b11, 2'b10, 2'b10, 2'b10};
    logic [3:0] expq  [4] = '{4'd4, 4'd1, 4'd8, 4'd5};
    logic       expr  [4] = '{0, 0, 1, 0};
    logic       expl  [4] = '{1, 0, 0, 0};
    d = 4'd4;
    for (int i = 0; i < 4; i++) begin
      modo = modes[i];
      tick();
      checks += 3;
      if (q !== expq[i]) begin fails++; $display("[TB] FAIL step_q %0d: got %0d want %0d", i, q, expq[i]); end
      if (rco !== expr[i]) begin fails++; $display("[TB] FAIL step_rco %0d: got %b want %b", i, rco, expr[i]); end
      if (load !== expl[i]) begin fails++; $display("[TB] FAIL step_load %0d: got %b want %b", i, load, expl[i]); end
    end
  endtask

  task automatic test_hold();
    enable = 1'b0; modo = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 3;
      if (q !== 4'd5) begin fails++; $display("[TB] FAIL hold_q %0d: got %0d want 5", i, q); end
      if (rco !== 1'b0) begin fails++; $display("[TB] FAIL hold_rco %0d: got %b want 0", i, rco); end
      if (load !== 1'b0) begin fails++; $display("[TB] FAIL hold_load %0d: got %b want 0", i, load); end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (q !== 4'd4) begin fails++; $display("[TB] FAIL hold_release_q: got %0d want 4", q); end
  endtask

  task automatic test_load_wrap();
    modo = 2'b11; d = 4'd15;
    tick();
    checks += 2;
    if (q !== 4'd15) begin fails++; $display("[TB] FAIL load15_q: got %0d want 15", q); end
    if (load !== 1'b1) begin fails++; $display("[TB] FAIL load15_load: got %b want 1", load); end
    modo = 2'b00;
    tick();
    checks += 3;
    if (q !== 4'd0) begin fails++; $display("[TB] FAIL over_wrap_q: got %0d want 0", q); end
    if (rco !== 1'b1) begin fails++; $display("[TB] FAIL over_wrap_rco: got %b want 1", rco); end
    if (load !== 1'b0) begin fails++; $display("[TB] FAIL over_wrap_load: got %b want 0", load); end
    for (int i = 1; i <= 7; i++) tick();
    checks++;
    if (q !== 4'd7) begin fails++; $display("[TB] FAIL count_to_7: got %0d want 7", q); end
    reset = 1'b1;
    tick();
    checks++;
    if (q !== 4'd0) begin fails++; $display("[TB] FAIL midcount_reset_q: got %0d want 0", q); end
    reset = 1'b0;
    tick();
    checks++;
    if (q !== 4'd1) begin fails++; $display("[TB] FAIL post_reset_q: got %0d want 1", q); end
  endtask

  task automatic test_borrow();
    // From Q=1: down to 0, then borrow reloads LIMIT.
    modo = 2'b01;
    tick();
    checks += 2;
    if (q !== 4'd0) begin fails++; $display("[TB] FAIL down_q: got %0d want 0", q); end
    if (rco !== 1'b0) begin fails++; $display("[TB] FAIL down_rco: got %b want 0", rco); end
    tick();
    checks += 2;
    if (q !== 4'd9) begin fails++; $display("[TB] FAIL borrow_q: got %0d want 9", q); end
    if (rco !== 1'b1) begin fails++; $display("[TB] FAIL borrow_rco: got %b want 1", rco); end
    // LIMIT lowered below Q: decrement continues without a borrow pulse.
    limit = 4'd5;
    tick();
    checks += 2;
    if (q !== 4'd8) begin fails++; $display("[TB] FAIL above_limit_down_q: got %0d want 8", q); end
    if (rco !== 1'b0) begin fails++; $display("[TB] FAIL above_limit_down_rco: got %b want 0", rco); end
    // Back-to-back load then step-down.
    modo = 2'b11; d = 4'd0; limit = 4'd1;
    tick();
    modo = 2'b10;
    tick();
    checks += 3;
`ifdef CONTADOR_N_SAT_EN
    if (q !== 4'd0) begin fails++; $display("[TB] FAIL neg_wrap_q: got %0d want 0", q); end
`else
    if (q !== 4'd1) begin fails++; $display("[TB] FAIL neg_wrap_q: got %0d want 1", q); end
`endif
    if (rco !== 1'b1) begin fails++; $display("[TB] FAIL neg_wrap_rco: got %b want 1", rco); end
    if (load !== 1'b0) begin fails++; $display("[TB] FAIL neg_wrap_load: got %b want 0", load); end
    limit = 4'd9;
  endtask

`ifdef CONTADOR_N_SAT_EN
  task automatic test_saturation();
    modo = 2'b11; d = 4'd8;
    tick();
    modo = 2'b00;
    tick();
    checks++;
    if (q !== 4'd9) begin fails++; $display("[TB] FAIL sat_up_q: got %0d want 9", q); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 2;
      if (q !== 4'd9) begin fails++; $display("[TB] FAIL sat_hold_q %0d: got %0d want 9", i, q); end
      if (rco !== 1'b1) begin fails++; $display("[TB] FAIL sat_hold_rco %0d: got %b want 1", i, rco); end
    end
    modo = 2'b11; d = 4'd2;
    tick();
    modo = 2'b10;
    tick();
    checks += 2;
    if (q !== 4'd0) begin fails++; $display("[TB] FAIL sat_step_q: got %0d want 0", q); end
    if (rco !== 1'b1) begin fails++; $display("[TB] FAIL sat_step_rco: got %b want 1", rco); end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    reset = 1'b1; enable = 1'b0; modo = 2'b00; d = 4'd0; limit = 4'd9;
    #2;
    test_reset();
`ifdef CONTADOR_N_SAT_EN
    reset = 1'b0;
    test_saturation();
`else
    test_count_up();
    test_step_down();
    test_hold();
    test_load_wrap();
    test_borrow();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
